// File: rtl/axi_ready_policy_gen.sv
// Multi-channel AXI READY generator: each valid/ready channel gets its own run-time
// back-pressure policy (no back-pressure, single-shot delay, oscillator, LFSR random).
`timescale 1ns/1ps
module axi_ready_policy_gen #(
    parameter int          NUM_CH    = 5,
    parameter int          CNT_W     = 8,
    parameter int          MAX_STALL = 64,
    parameter logic [15:0] LFSR_SEED = 16'hACE1,
    localparam int         CH_W      = (NUM_CH > 1) ? $clog2(NUM_CH) : 1
) (
    input  logic                 aclk,
    input  logic                 aresetn,
    input  logic                 cfg_wr,
    input  logic [CH_W-1:0]      cfg_ch,
    input  logic [1:0]           cfg_mode,
    input  logic [CNT_W-1:0]     cfg_low,
    input  logic [CNT_W-1:0]     cfg_high,
    input  logic [7:0]           cfg_thresh,
    input  logic                 cnt_clr,
    input  logic [NUM_CH-1:0]    valid,
    output logic [NUM_CH-1:0]    ready,
    output logic [NUM_CH*16-1:0] hs_cnt,
    output logic [NUM_CH-1:0]    stall_force
);

    typedef enum logic [1:0] {
        MODE_NOBP   = 2'd0,
        MODE_SINGLE = 2'd1,
        MODE_OSC    = 2'd2,
        MODE_RANDOM = 2'd3
    } mode_e;

    // Stall counter can reach MAX_STALL itself (the cycle the forced ready is presented).
    localparam int                STALL_W   = (MAX_STALL > 1) ? $clog2(MAX_STALL + 1) : 1;
    localparam logic [STALL_W-1:0] STALL_LIM = STALL_W'(MAX_STALL - 1);

    generate
        for (genvar gi = 0; gi < NUM_CH; gi++) begin : g_ch
            localparam logic [15:0] SEED_X = LFSR_SEED ^ 16'(gi);
            localparam logic [15:0] SEED   = (SEED_X == 16'd0) ? 16'd1 : SEED_X;

            mode_e              mode_q,   mode_d;
            logic [CNT_W-1:0]   low_q,    low_d;
            logic [CNT_W-1:0]   high_q,   high_d;
            logic [7:0]         thresh_q, thresh_d;
            logic [CNT_W-1:0]   cnt_q,    cnt_d;
            logic               phase_q,  phase_d;
            logic [15:0]        lfsr_q,   lfsr_d;
            logic [STALL_W-1:0] stall_q,  stall_d;
            logic               ready_q,  ready_d;
            logic               sf_q,     sf_d;
            logic [15:0]        hs_q,     hs_d;

            logic               cfg_hit;
            logic               hs;
            logic               stall_hit;
            logic [CNT_W-1:0]   low_end;
            logic [CNT_W-1:0]   high_end;

            assign cfg_hit   = cfg_wr & (cfg_ch == CH_W'(gi));
            assign hs        = valid[gi] & ready_q;
            assign stall_hit = (MAX_STALL != 0) && (stall_q == STALL_LIM);
            // Phase lengths of zero behave as one cycle.
            assign low_end   = (low_q  == '0) ? '0 : low_q  - 1'b1;
            assign high_end  = (high_q == '0) ? '0 : high_q - 1'b1;

            always_comb begin
                mode_d   = mode_q;
                low_d    = low_q;
                high_d   = high_q;
                thresh_d = thresh_q;
                cnt_d    = cnt_q;
                phase_d  = phase_q;
                stall_d  = stall_q;
                ready_d  = ready_q;
                sf_d     = 1'b0;
                lfsr_d   = {lfsr_q[14:0], lfsr_q[15] ^ lfsr_q[13] ^ lfsr_q[12] ^ lfsr_q[10]};

                if (cnt_clr) begin
                    hs_d = '0;
                end else if (hs && (hs_q != 16'hFFFF)) begin
                    hs_d = hs_q + 16'd1;
                end else begin
                    hs_d = hs_q;
                end

                // A config write overrides whatever the policy would have done this edge.
                if (cfg_hit) begin
                    mode_d   = mode_e'(cfg_mode);
                    low_d    = cfg_low;
                    high_d   = cfg_high;
                    thresh_d = cfg_thresh;
                    cnt_d    = '0;
                    stall_d  = '0;
                    phase_d  = 1'b0;
                    ready_d  = (cfg_mode == MODE_NOBP);
                end else begin
                    case (mode_q)
                        MODE_NOBP: ready_d = 1'b1;
                        MODE_SINGLE: begin
                            if (hs) begin
                                ready_d = 1'b0;
                                cnt_d   = '0;
                            end else if (valid[gi]) begin
                                if (cnt_q == low_q) ready_d = 1'b1;
                                else                cnt_d   = cnt_q + 1'b1;
                            end
                        end
                        MODE_OSC: begin
                            if (!phase_q) begin
                                if (cnt_q == low_end) begin
                                    phase_d = 1'b1;
                                    cnt_d   = '0;
                                    ready_d = 1'b1;
                                end else begin
                                    cnt_d   = cnt_q + 1'b1;
                                    ready_d = 1'b0;
                                end
                            end else begin
                                if (cnt_q == high_end) begin
                                    phase_d = 1'b0;
                                    cnt_d   = '0;
                                    ready_d = 1'b0;
                                end else begin
                                    cnt_d   = cnt_q + 1'b1;
                                    ready_d = 1'b1;
                                end
                            end
                        end
                        MODE_RANDOM: begin
                            ready_d = (lfsr_q[7:0] < thresh_q) | stall_hit;
                            sf_d    = stall_hit;
                            if (hs || !valid[gi])     stall_d = '0;
                            else if (stall_q != '1)   stall_d = stall_q + 1'b1;
                        end
                        default: ready_d = 1'b0;
                    endcase
                end
            end

            always_ff @(posedge aclk or negedge aresetn) begin
                if (!aresetn) begin
                    mode_q   <= MODE_NOBP;
                    low_q    <= '0;
                    high_q   <= '0;
                    thresh_q <= '0;
                    cnt_q    <= '0;
                    phase_q  <= 1'b0;
                    lfsr_q   <= SEED;
                    stall_q  <= '0;
                    ready_q  <= 1'b0;
                    sf_q     <= 1'b0;
                    hs_q     <= '0;
                end else begin
                    mode_q   <= mode_d;
                    low_q    <= low_d;
                    high_q   <= high_d;
                    thresh_q <= thresh_d;
                    cnt_q    <= cnt_d;
                    phase_q  <= phase_d;
                    lfsr_q   <= lfsr_d;
                    stall_q  <= stall_d;
                    ready_q  <= ready_d;
                    sf_q     <= sf_d;
                    hs_q     <= hs_d;
                end
            end

            assign ready[gi]            = ready_q;
            assign stall_force[gi]      = sf_q;
            assign hs_cnt[16*gi +: 16]  = hs_q;
        end
    endgenerate

endmodule

// File: tb/tb_axi_ready_policy_gen.sv
// Randomised scoreboard bench for axi_ready_policy_gen: a per-channel policy model
// predicts ready/stall_force/hs_cnt for every edge; a monitor compares them.
`timescale 1ns/1ps
module tb_axi_ready_policy_gen;

    localparam int NUM_CH = 5;
    localparam int CNT_W  = 8;
    localparam int MAX_ST = 64;
    localparam int NOBP = 0, SINGLE = 1, OSC = 2, RAND = 3;

    logic                 aclk = 1'b0;
    logic                 aresetn;
    logic                 cfg_wr;
    logic [2:0]           cfg_ch;
    logic [1:0]           cfg_mode;
    logic [CNT_W-1:0]     cfg_low;
    logic [CNT_W-1:0]     cfg_high;
    logic [7:0]           cfg_thresh;
    logic                 cnt_clr;
    logic [NUM_CH-1:0]    valid;
    logic [NUM_CH-1:0]    ready;
    logic [NUM_CH*16-1:0] hs_cnt;
    logic [NUM_CH-1:0]    stall_force;

    axi_ready_policy_gen #(
        .NUM_CH(NUM_CH), .CNT_W(CNT_W), .MAX_STALL(MAX_ST), .LFSR_SEED(16'hACE1)
    ) dut (
        .aclk(aclk), .aresetn(aresetn), .cfg_wr(cfg_wr), .cfg_ch(cfg_ch),
        .cfg_mode(cfg_mode), .cfg_low(cfg_low), .cfg_high(cfg_high),
        .cfg_thresh(cfg_thresh), .cnt_clr(cnt_clr), .valid(valid),
        .ready(ready), .hs_cnt(hs_cnt), .stall_force(stall_force)
    );

    always #5 aclk = ~aclk;

    typedef struct {
        logic [NUM_CH-1:0]    rdy;
        logic [NUM_CH-1:0]    sf;
        logic [NUM_CH*16-1:0] hs;
    } exp_t;
    exp_t exp_q[$];

    int n_assert = 0;
    int n_fail   = 0;
    int cycle    = 0;

    // Behavioural policy model, one entry per channel.
    int          m_mode[NUM_CH], m_low[NUM_CH], m_high[NUM_CH], m_thr[NUM_CH];
    int          m_wait[NUM_CH], m_pos[NUM_CH], m_stall[NUM_CH], m_hs[NUM_CH];
    bit          m_ready[NUM_CH], m_sf[NUM_CH];
    logic [15:0] m_lfsr[NUM_CH];

    function automatic void chk(string nm, logic [NUM_CH*16-1:0] act, logic [NUM_CH*16-1:0] req);
        n_assert++;
        if (act !== req) begin
            n_fail++;
            $display("FAIL %s cycle=%0d actual=%h required=%h", nm, cycle, act, req);
        end
    endfunction

    function automatic logic [15:0] lfsr_next(input logic [15:0] v);
        return {v[14:0], v[15] ^ v[13] ^ v[12] ^ v[10]};
    endfunction

    function automatic void model_reset();
        logic [15:0] s;
        for (int i = 0; i < NUM_CH; i++) begin
            m_mode[i] = NOBP; m_low[i] = 0; m_high[i] = 0; m_thr[i] = 0;
            m_wait[i] = 0; m_pos[i] = 0; m_stall[i] = 0; m_hs[i] = 0;
            m_ready[i] = 1'b0; m_sf[i] = 1'b0;
            s = 16'hACE1 ^ 16'(i);
            m_lfsr[i] = (s == 16'd0) ? 16'd1 : s;
        end
    endfunction

    // Predict the state after the coming rising edge from the inputs now applied.
    function automatic void model_step();
        exp_t        e;
        bit          v, hs, r_n, sf_n, frc;
        int          lo, hi;
        logic [15:0] lf;
        if (!aresetn) begin
            model_reset();
        end else begin
            for (int i = 0; i < NUM_CH; i++) begin
                v    = valid[i];
                hs   = v && m_ready[i];
                r_n  = m_ready[i];
                sf_n = 1'b0;
                lf   = m_lfsr[i];
                m_lfsr[i] = lfsr_next(lf);
                if (cnt_clr)                    m_hs[i] = 0;
                else if (hs && m_hs[i] < 65535) m_hs[i]++;
                if (cfg_wr && int'(cfg_ch) == i) begin
                    m_mode[i] = int'(cfg_mode); m_low[i] = int'(cfg_low);
                    m_high[i] = int'(cfg_high); m_thr[i] = int'(cfg_thresh);
                    m_wait[i] = 0; m_pos[i] = 0; m_stall[i] = 0;
                    r_n = (cfg_mode == 2'(NOBP));
                end else begin
                    case (m_mode[i])
                        NOBP: r_n = 1'b1;
                        SINGLE: begin
                            if (hs) begin
                                r_n = 1'b0; m_wait[i] = 0;
                            end else if (v) begin
                                m_wait[i]++;
                                if (m_wait[i] == m_low[i] + 1) r_n = 1'b1;
                            end
                        end
                        OSC: begin
                            lo = (m_low[i]  == 0) ? 1 : m_low[i];
                            hi = (m_high[i] == 0) ? 1 : m_high[i];
                            m_pos[i] = (m_pos[i] + 1) % (lo + hi);
                            r_n = (m_pos[i] >= lo);
                        end
                        default: begin
                            frc  = (MAX_ST != 0) && (m_stall[i] == MAX_ST - 1);
                            r_n  = (int'(lf[7:0]) < m_thr[i]) || frc;
                            sf_n = frc;
                            m_stall[i] = (v && !hs) ? m_stall[i] + 1 : 0;
                        end
                    endcase
                end
                m_ready[i] = r_n;
                m_sf[i]    = sf_n;
            end
        end
        for (int i = 0; i < NUM_CH; i++) begin
            e.rdy[i] = m_ready[i];
            e.sf[i]  = m_sf[i];
            e.hs[16*i +: 16] = 16'(m_hs[i]);
        end
        exp_q.push_back(e);
    endfunction

    task automatic cyc();
        model_step();
        @(negedge aclk);
        cycle++;
    endtask

    task automatic do_cfg(input int ch, input int md, input int lo, input int hi,
                          input int th, input logic [NUM_CH-1:0] v, input bit clr);
        cfg_wr = 1'b1; cfg_ch = 3'(ch); cfg_mode = 2'(md);
        cfg_low = 8'(lo); cfg_high = 8'(hi); cfg_thresh = 8'(th);
        valid = v; cnt_clr = clr;
        $display("cfg   cycle=%0d ch=%0d mode=%0d low=%0d high=%0d thresh=%0d clr=%0d",
                 cycle, ch, md, lo, hi, th, clr);
        cyc();
        cfg_wr = 1'b0; cnt_clr = 1'b0;
    endtask

    task automatic do_reset();
        aresetn = 1'b0;
        #1;
        chk("rst_ready", NUM_CH*16'(ready), '0);
        chk("rst_hs_cnt", hs_cnt, '0);
        chk("rst_stall_force", NUM_CH*16'(stall_force), '0);
        $display("reset cycle=%0d", cycle);
        cyc();
        cyc();
        aresetn = 1'b1;
    endtask

    // Monitor: one expectation per rising edge, compared 1 ns after the edge.
    initial begin
        exp_t e;
        forever begin
            @(posedge aclk);
            #1;
            if (exp_q.size() > 0) begin
                e = exp_q.pop_front();
                chk("ready", NUM_CH*16'(ready), NUM_CH*16'(e.rdy));
                chk("stall_force", NUM_CH*16'(stall_force), NUM_CH*16'(e.sf));
                chk("hs_cnt", hs_cnt, e.hs);
            end
        end
    end

    initial begin
        #3ms;
        $display("FAIL watchdog cycle=%0d actual=running required=finished", cycle);
        $fatal(1, "timeout");
    end

    initial begin
        int          nr, nsf;
        logic [9:0]  pat, want;
        aresetn = 1'b0; cfg_wr = 1'b0; cfg_ch = '0; cfg_mode = '0; cfg_low = '0;
        cfg_high = '0; cfg_thresh = '0; cnt_clr = 1'b0; valid = '0;
        model_reset();
        @(negedge aclk);
        repeat (3) cyc();

        // T1: all NOBP after reset, continuous valid
        aresetn = 1'b1; valid = '1;
        repeat (11) cyc();
        for (int i = 0; i < NUM_CH; i++) chk("t1_hs_cnt", 80'(hs_cnt[16*i +: 16]), 80'd10);
        $display("t1    cycle=%0d nobp burst done", cycle);

        // T2: ch0 SINGLE low=2 with valid held
        do_cfg(0, SINGLE, 2, 0, 0, '0, 1'b1);
        valid = 5'b00001;
        repeat (20) cyc();
        chk("t2_hs_cnt0", 80'(hs_cnt[15:0]), 80'd5);
        $display("t2    cycle=%0d single done", cycle);

        // T3: ch1 OSC patterns
        do_cfg(1, OSC, 3, 2, 0, '0, 1'b0);
        pat = '0;
        for (int j = 0; j < 10; j++) begin pat = {pat[8:0], ready[1]}; cyc(); end
        want = 10'b0001100011;
        chk("t3_osc_3_2", 80'(pat), 80'(want));
        do_cfg(1, OSC, 0, 0, 0, '0, 1'b0);
        pat = '0;
        for (int j = 0; j < 10; j++) begin pat = {pat[8:0], ready[1]}; cyc(); end
        want = 10'b0101010101;
        chk("t3_osc_0_0", 80'(pat), 80'(want));

        // T4: ch2 RANDOM thresh=0, only the stall limit opens ready
        do_cfg(2, RAND, 0, 0, 0, 5'b00100, 1'b0);
        nr = 0; nsf = 0;
        repeat (200) begin cyc(); nr += int'(ready[2]); nsf += int'(stall_force[2]); end
        chk("t4_ready_pulses", 80'(nr), 80'd3);
        chk("t4_force_pulses", 80'(nsf), 80'd3);
        $display("t4    cycle=%0d ready_pulses=%0d force_pulses=%0d", cycle, nr, nsf);

        // T5: ch3 RANDOM thresh=128, twice from reset
        for (int run = 0; run < 2; run++) begin
            valid = '0;
            do_reset();
            do_cfg(3, RAND, 0, 0, 128, 5'b01000, 1'b0);
            nr = 0;
            repeat (10000) begin cyc(); nr += int'(ready[3]); end
            chk("t5_duty_in_range", 80'((nr >= 4500) && (nr <= 5500)), 80'd1);
            $display("t5    cycle=%0d run=%0d ready_cycles=%0d", cycle, run, nr);
        end

        // T6: config during a handshake, clear during a handshake, reset mid-burst
        do_cfg(0, NOBP, 0, 0, 0, 5'b00001, 1'b0);
        repeat (3) cyc();
        do_cfg(0, SINGLE, 5, 0, 0, 5'b00001, 1'b0);
        chk("t6_cfg_drops_ready", 80'(ready[0]), 80'd0);
        do_cfg(0, NOBP, 0, 0, 0, 5'b00001, 1'b0);
        repeat (3) cyc();
        cnt_clr = 1'b1;
        cyc();
        cnt_clr = 1'b0;
        chk("t6_clr_beats_hs", 80'(hs_cnt[15:0]), 80'd0);
        repeat (5) begin valid = NUM_CH'($urandom); cyc(); end
        do_reset();

        // Random mixed traffic with occasional config writes and resets
        for (int n = 0; n < 3000; n++) begin
            if ($urandom_range(0, 29) == 0) begin
                do_cfg(int'($urandom_range(0, 7)), int'($urandom_range(0, 3)),
                       int'($urandom_range(0, 5)), int'($urandom_range(0, 5)),
                       int'($urandom_range(0, 255)), NUM_CH'($urandom), 1'($urandom_range(0, 7) == 0));
            end else if ($urandom_range(0, 999) == 0) begin
                do_reset();
            end else begin
                valid   = NUM_CH'($urandom);
                cnt_clr = ($urandom_range(0, 99) == 0);
                cyc();
                cnt_clr = 1'b0;
            end
        end

        @(posedge aclk);
        #2;
        chk("scoreboard_drained", 80'(exp_q.size()), 80'd0);
        $display("End of test - %0d assertions evaluated, %0d failures", n_assert, n_fail);
        $finish;
    end

endmodule
